audio_note_player: RTL

AUDIO_NOTE_PLAYER -- requirements
Module: audio_note_player

---
 rtl/audio_pkg.sv | 55 +++++
 rtl/cmd_fifo.sv | 81 ++++++++
 rtl/audio_note_player.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio note player.
// Holds the default register addresses, command word field positions,
// status/control bit positions, the player state encoding and small helpers
// used to pack/unpack command and status words.
package audio_pkg;

  // Default word addresses of the command and status/control registers
  localparam logic [31:0] DEF_CMD_ADDR    = 32'd4098;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'd4099;

  // Command word layout: [31:20] duration in ticks, [19:0] half-period in clocks
  localparam int CMD_DUR_MSB  = 31;
  localparam int CMD_DUR_LSB  = 20;
  localparam int CMD_HALF_MSB = 19;
  localparam int CMD_HALF_LSB = 0;
  localparam int DUR_W        = CMD_DUR_MSB - CMD_DUR_LSB + 1;
  localparam int HALF_W       = CMD_HALF_MSB - CMD_HALF_LSB + 1;

  // Status word layout
  localparam int STAT_COUNT_MSB = 7;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_BUSY_BIT  = 0;

  // Control write bits (store to the status address)
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Player state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  function automatic logic [DUR_W-1:0] cmd_duration(input logic [31:0] word);
    return word[CMD_DUR_MSB:CMD_DUR_LSB];
  endfunction

  function automatic logic [HALF_W-1:0] cmd_half_period(input logic [31:0] word);
    return word[CMD_HALF_MSB:CMD_HALF_LSB];
  endfunction

  function automatic logic [31:0] status_word(input logic [3:0] count,
                                              input logic       overflow,
                                              input logic       busy);
    logic [31:0] word;
    word = 32'd0;
    word[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
    word[STAT_OVF_BIT]                  = overflow;
    word[STAT_BUSY_BIT]                 = busy;
    return word;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO for the audio note player.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   flush         - synchronous clear of pointers and count (wins over push/pop)
//   push, wdata   - write request; accepted when not full or when popping
//   pop           - read request; ignored when empty
//   rdata         - head entry (valid while not empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries (0..DEPTH)
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});
  assign rdata = mem[rd_ptr];

  // Qualify requests: a pop frees a slot, so a push into a full FIFO is legal
  // when it coincides with an effective pop.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
  end

  // Pointer and count bookkeeping; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/audio_note_player.sv
// Memory-mapped square-wave note player.
// A store to CMD_ADDR queues a note command ([31:20] duration in ticks,
// [19:0] half-period in clocks, half-period 0 = rest). Notes are played
// back-to-back from the FIFO. A store to STATUS_ADDR clears overflow (bit 1)
// and/or stops playback and flushes the queue (bit 0).
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   wEn, addr, dataIn - processor store interface
//   dataOut  - status word while addr==STATUS_ADDR, else 0 (combinational)
//   audioOut - registered square-wave output
//   busy     - player active or commands pending
module audio_note_player
  import audio_pkg::*;
#(
  parameter logic [31:0] CMD_ADDR    = DEF_CMD_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          TICK_DIV    = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wEn,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        audioOut,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t             state;
  state_t             fsm_next;
  state_t             state_next;

  logic               cmd_wr;
  logic               stat_wr;
  logic               flush;
  logic               clr_ovf;
  logic               push_req;
  logic               pop;
  logic               fifo_pop;
  logic               note_end;
  logic               tick_wrap;

  logic [31:0]        fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [3:0]         count_field;

  logic [31:0]        cmd_word;
  logic [HALF_W-1:0]  half_period;
  logic [DUR_W-1:0]   remaining;
  logic [HALF_W-1:0]  tone_cnt;
  logic [TW-1:0]      tick_cnt;
  logic               audio_level;
  logic               overflow;

  // Bus decode; a flush suppresses any command push in the same cycle
  always_comb begin
    cmd_wr   = wEn && (addr == CMD_ADDR);
    stat_wr  = wEn && (addr == STATUS_ADDR);
    flush    = stat_wr && dataIn[CTRL_FLUSH_BIT];
    clr_ovf  = stat_wr && dataIn[CTRL_CLR_OVF_BIT];
    push_req = cmd_wr && !flush;
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (dataIn),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tick_wrap   = (tick_cnt == TW'(TICK_DIV - 1));
  assign state_next  = flush ? IDLE : fsm_next;
  assign fifo_pop    = pop && !flush;
  assign busy        = (state != IDLE) || !fifo_empty;
  assign audioOut    = audio_level;
  assign count_field = 4'(fifo_count);
  assign dataOut     = (addr == STATUS_ADDR) ? status_word(count_field, overflow, busy) : 32'd0;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and pop decisions; a note ends on the tick that takes the
  // remaining duration from 1 to 0
  always_comb begin
    fsm_next = state;
    pop      = 1'b0;
    note_end = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          fsm_next = LOAD;
        end else begin
          fsm_next = IDLE;
        end
      end
      LOAD: begin
        if (cmd_duration(cmd_word) == {DUR_W{1'b0}}) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            fsm_next = LOAD;
          end else begin
            fsm_next = IDLE;
          end
        end else begin
          fsm_next = PLAY;
        end
      end
      PLAY: begin
        if (tick_wrap && (remaining == DUR_W'(1))) begin
          note_end = 1'b1;
          if (!fifo_empty) begin
            pop      = 1'b1;
            fsm_next = LOAD;
          end else begin
            fsm_next = IDLE;
          end
        end else begin
          fsm_next = PLAY;
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  // Sticky overflow: a command push into a full FIFO with no pop is lost
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

  // Note datapath: popped command capture, field latch, tone and tick counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_word    <= 32'd0;
      half_period <= {HALF_W{1'b0}};
      remaining   <= {DUR_W{1'b0}};
      tone_cnt    <= {HALF_W{1'b0}};
      tick_cnt    <= {TW{1'b0}};
      audio_level <= 1'b0;
    end else if (flush) begin
      cmd_word    <= 32'd0;
      half_period <= {HALF_W{1'b0}};
      remaining   <= {DUR_W{1'b0}};
      tone_cnt    <= {HALF_W{1'b0}};
      tick_cnt    <= {TW{1'b0}};
      audio_level <= 1'b0;
    end else begin
      if (fifo_pop) begin
        cmd_word <= fifo_rdata;
      end else begin
        cmd_word <= cmd_word;
      end
      case (state)
        LOAD: begin
          half_period <= cmd_half_period(cmd_word);
          remaining   <= cmd_duration(cmd_word);
          tone_cnt    <= {HALF_W{1'b0}};
          tick_cnt    <= {TW{1'b0}};
          audio_level <= 1'b0;
        end
        PLAY: begin
          // Tone generator; a zero half-period is a rest
          if (half_period == {HALF_W{1'b0}}) begin
            tone_cnt    <= {HALF_W{1'b0}};
            audio_level <= 1'b0;
          end else if (tone_cnt == (half_period - HALF_W'(1))) begin
            tone_cnt    <= {HALF_W{1'b0}};
            audio_level <= ~audio_level;
          end else begin
            tone_cnt    <= tone_cnt + HALF_W'(1);
            audio_level <= audio_level;
          end
          // Duration ticks
          if (tick_wrap) begin
            tick_cnt  <= {TW{1'b0}};
            remaining <= remaining - DUR_W'(1);
          end else begin
            tick_cnt  <= tick_cnt + TW'(1);
            remaining <= remaining;
          end
          // End of note silences the output (overrides a coincident toggle)
          if (note_end) begin
            audio_level <= 1'b0;
          end
        end
        default: begin
          audio_level <= 1'b0;
        end
      endcase
    end
  end

endmodule
